// File: rtl/dibit_packer_pkg.sv
// Shared constants and helpers for the dibit packer and its byte FIFO.
// Later framer stages import the same definitions.
package dibit_packer_pkg;

  localparam int DIBIT_W         = 2;
  localparam int BYTE_W          = 8;
  localparam int DIBITS_PER_BYTE = 4;
  localparam int CNT_W           = 2;

  typedef logic [BYTE_W-1:0]  byte_t;
  typedef logic [DIBIT_W-1:0] dibit_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dibit_packer_if.sv
// Dibit input, byte output handshake and status bundle of the dibit packer.
// The master side drives the dibits and the ready; the slave side is the packer.
interface dibit_packer_if
  import dibit_packer_pkg::*;
#(
  parameter int DEPTH = 4
) ();

  dibit_t                 D;
  logic                   CE;
  logic                   FLUSH;
  byte_t                  Q;
  logic                   DV;
  logic                   RDY;
  logic [clog2(DEPTH):0]  FILL;
  logic                   OVF;
  logic                   CLR;

  modport master (
    output D, CE, FLUSH, RDY, CLR,
    input  Q, DV, FILL, OVF
  );

  modport slave (
    input  D, CE, FLUSH, RDY, CLR,
    output Q, DV, FILL, OVF
  );

endinterface

// File: rtl/byte_fifo_sync.sv
// Synchronous FIFO with a registered head: Q/DV reflect the oldest entry
// from the edge after it is written. Generic in width and power-of-two depth.
module byte_fifo_sync
  import dibit_packer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      Q,
  output logic                  DV,
  output logic [clog2(DEPTH):0] FILL,
  output logic                  full
);

  localparam int PTR_W  = clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_next;
  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [WIDTH-1:0]  head_next;
  logic [WIDTH-1:0]  q_reg;
  logic              dv_reg;
  logic              pop_ok;
  logic              accept;

  assign full   = (fill == FILL_W'(DEPTH));
  assign pop_ok = pop && dv_reg;
  // A pop frees a slot on the same edge, so a push into a full FIFO still fits.
  assign accept = push && (!full || pop_ok);

  always_comb begin
    rd_next   = pop_ok ? rd_ptr + PTR_W'(1) : rd_ptr;
    fill_next = fill;
    case ({accept, pop_ok})
      2'b10:   fill_next = fill + FILL_W'(1);
      2'b01:   fill_next = fill - FILL_W'(1);
      default: fill_next = fill;
    endcase
    // The incoming byte bypasses memory when it becomes the new head.
    head_next = (accept && (wr_ptr == rd_next)) ? din : mem[rd_next];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
      q_reg  <= '0;
      dv_reg <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_next;
      fill   <= fill_next;
      dv_reg <= (fill_next != '0);
      if (fill_next != '0) q_reg <= head_next;
    end
  end

  assign Q    = q_reg;
  assign DV   = dv_reg;
  assign FILL = fill;

endmodule

// File: rtl/dibit_packer.sv
// Packs four strobed dibits into a byte and queues completed bytes in a FIFO,
// with zero-padded flush of partial bytes and a sticky overflow flag.
module dibit_packer
  import dibit_packer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic          CLK,
  input logic          RST,
  dibit_packer_if.slave bus
);

  logic [CNT_W-1:0] cnt;
  byte_t            asm_byte;
  byte_t            placed;
  byte_t            push_data;
  logic             complete;
  logic             flush_push;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             ovf;

  function automatic byte_t place_dibit(input byte_t cur, input dibit_t d,
                                        input logic [CNT_W-1:0] slot);
    byte_t r;
    int    lo;
    r  = cur;
    lo = MSB_FIRST ? (BYTE_W - DIBIT_W - DIBIT_W * int'(slot))
                   : (DIBIT_W * int'(slot));
    r[lo +: DIBIT_W] = d;
    return r;
  endfunction

  always_comb begin
    placed     = place_dibit(asm_byte, bus.D, cnt);
    complete   = bus.CE && (cnt == CNT_W'(DIBITS_PER_BYTE - 1));
    // A flush with nothing assembled and no new dibit is a no-op.
    flush_push = bus.FLUSH && ((cnt != '0) || bus.CE);
    push       = complete || flush_push;
    push_data  = bus.CE ? placed : asm_byte;
    pop        = bus.DV && bus.RDY;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt      <= '0;
      asm_byte <= '0;
    end else if (push) begin
      cnt      <= '0;
      asm_byte <= '0;
    end else if (bus.CE) begin
      cnt      <= cnt + CNT_W'(1);
      asm_byte <= placed;
    end
  end

  // A new overflow outranks a simultaneous clear.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf <= 1'b1;
    end else if (bus.CLR) begin
      ovf <= 1'b0;
    end
  end

  assign bus.OVF = ovf;

  byte_fifo_sync #(
    .WIDTH (BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .push (push),
    .din  (push_data),
    .pop  (pop),
    .Q    (bus.Q),
    .DV   (bus.DV),
    .FILL (bus.FILL),
    .full (fifo_full)
  );

endmodule

// File: tb/tb_dibit_packer.sv
// Directed bench for dibit_packer: MSB-first and LSB-first instances share stimulus;
// a vector table covers packing/flush, hand sequences cover overflow, pop+push and reset.
module tb_dibit_packer;
  import dibit_packer_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  dibit_packer_if #(.DEPTH(4)) bm ();
  dibit_packer_if #(.DEPTH(4)) bl ();

  assign bl.D     = bm.D;
  assign bl.CE    = bm.CE;
  assign bl.FLUSH = bm.FLUSH;
  assign bl.RDY   = bm.RDY;
  assign bl.CLR   = bm.CLR;

  dibit_packer #(.DEPTH(4), .MSB_FIRST(1'b1)) dut_m (.CLK(clk), .RST(rst), .bus(bm));
  dibit_packer #(.DEPTH(4), .MSB_FIRST(1'b0)) dut_l (.CLK(clk), .RST(rst), .bus(bl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] d;
    logic       ce;
    logic       flush;
    logic       rdy;
    logic [7:0] qm;
    logic [7:0] ql;
    logic       dv;
    logic [2:0] fill;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rdy_last, input bit clr_last);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 4; i++) begin
      bm.D     = v[7-2*i -: 2];
      bm.CE    = 1'b1;
      bm.RDY   = (i == 3) ? rdy_last : 1'b0;
      bm.CLR   = (i == 3) ? clr_last : 1'b0;
      step();
    end
    bm.CE  = 1'b0;
    bm.RDY = 1'b0;
    bm.CLR = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] drain4 [4];
    logic [7:0] drain5 [4];
    total = 0;
    bad   = 0;

    tbl[0]  = '{2'd0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0};
    tbl[1]  = '{2'd3, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0};
    tbl[2]  = '{2'd1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0};
    tbl[3]  = '{2'd2, 1'b1, 1'b0, 1'b1, 8'h36, 8'h9C, 1'b1, 3'd1};
    tbl[4]  = '{2'd0, 1'b0, 1'b0, 1'b1, 8'h36, 8'h9C, 1'b0, 3'd0};
    tbl[5]  = '{2'd3, 1'b1, 1'b0, 1'b1, 8'h36, 8'h9C, 1'b0, 3'd0};
    tbl[6]  = '{2'd1, 1'b1, 1'b0, 1'b1, 8'h36, 8'h9C, 1'b0, 3'd0};
    tbl[7]  = '{2'd0, 1'b0, 1'b1, 1'b1, 8'hD0, 8'h07, 1'b1, 3'd1};
    tbl[8]  = '{2'd0, 1'b0, 1'b1, 1'b1, 8'hD0, 8'h07, 1'b0, 3'd0};
    tbl[9]  = '{2'd0, 1'b0, 1'b0, 1'b1, 8'hD0, 8'h07, 1'b0, 3'd0};
    tbl[10] = '{2'd1, 1'b1, 1'b0, 1'b0, 8'hD0, 8'h07, 1'b0, 3'd0};
    tbl[11] = '{2'd1, 1'b1, 1'b0, 1'b0, 8'hD0, 8'h07, 1'b0, 3'd0};
    tbl[12] = '{2'd1, 1'b1, 1'b0, 1'b0, 8'hD0, 8'h07, 1'b0, 3'd0};
    tbl[13] = '{2'd2, 1'b1, 1'b1, 1'b0, 8'h56, 8'h95, 1'b1, 3'd1};
    tbl[14] = '{2'd0, 1'b0, 1'b0, 1'b0, 8'h56, 8'h95, 1'b1, 3'd1};
    tbl[15] = '{2'd0, 1'b0, 1'b0, 1'b1, 8'h56, 8'h95, 1'b0, 3'd0};
    tbl[16] = '{2'd3, 1'b1, 1'b0, 1'b0, 8'h56, 8'h95, 1'b0, 3'd0};
    tbl[17] = '{2'd2, 1'b1, 1'b1, 1'b0, 8'hE0, 8'h0B, 1'b1, 3'd1};
    tbl[18] = '{2'd0, 1'b0, 1'b0, 1'b1, 8'hE0, 8'h0B, 1'b0, 3'd0};

    drain4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain5 = '{8'hA2, 8'hA3, 8'hA4, 8'h66};

    rst      = 1'b0;
    bm.D     = 2'd0;
    bm.CE    = 1'b0;
    bm.FLUSH = 1'b0;
    bm.RDY   = 1'b0;
    bm.CLR   = 1'b0;
    step();
    step();
    chk("reset_q",    32'(bm.Q),    32'h00);
    chk("reset_dv",   32'(bm.DV),   32'h0);
    chk("reset_fill", 32'(bm.FILL), 32'h0);
    chk("reset_ovf",  32'(bm.OVF),  32'h0);
    rst = 1'b1;

    // Packing order, flush variants and pop timing.
    for (int i = 0; i < 19; i++) begin
      bm.D     = tbl[i].d;
      bm.CE    = tbl[i].ce;
      bm.FLUSH = tbl[i].flush;
      bm.RDY   = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_dv", i),   32'(bm.DV),   32'(tbl[i].dv));
      chk($sformatf("vec%0d_fill", i), 32'(bm.FILL), 32'(tbl[i].fill));
      chk($sformatf("vec%0d_qm", i),   32'(bm.Q),    32'(tbl[i].qm));
      chk($sformatf("vec%0d_ql", i),   32'(bl.Q),    32'(tbl[i].ql));
      chk($sformatf("vec%0d_ovf", i),  32'(bm.OVF),  32'h0);
    end
    bm.CE    = 1'b0;
    bm.FLUSH = 1'b0;
    bm.RDY   = 1'b0;

    // Overflow: fifth byte dropped; clear on the same edge loses to the set.
    send_byte(8'h11, 1'b0, 1'b0);
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b0, 1'b0);
    send_byte(8'h44, 1'b0, 1'b0);
    chk("full_fill", 32'(bm.FILL), 32'd4);
    chk("full_ovf",  32'(bm.OVF),  32'h0);
    chk("full_q",    32'(bm.Q),    32'h11);
    send_byte(8'h55, 1'b0, 1'b1);
    chk("ovf_fill", 32'(bm.FILL), 32'd4);
    chk("ovf_set",  32'(bm.OVF),  32'h1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain4_q%0d", i),  32'(bm.Q),  32'(drain4[i]));
      chk($sformatf("drain4_dv%0d", i), 32'(bm.DV), 32'h1);
      bm.RDY = 1'b1;
      step();
    end
    bm.RDY = 1'b0;
    chk("drain4_empty_dv",   32'(bm.DV),   32'h0);
    chk("drain4_empty_fill", 32'(bm.FILL), 32'h0);
    chk("drain4_hold_q",     32'(bm.Q),    32'h44);
    chk("ovf_sticky",        32'(bm.OVF),  32'h1);
    bm.CLR = 1'b1;
    step();
    bm.CLR = 1'b0;
    chk("ovf_clr", 32'(bm.OVF), 32'h0);

    // Push into a full FIFO on the same edge as a pop.
    send_byte(8'hA1, 1'b0, 1'b0);
    send_byte(8'hA2, 1'b0, 1'b0);
    send_byte(8'hA3, 1'b0, 1'b0);
    send_byte(8'hA4, 1'b0, 1'b0);
    chk("pp_prefill", 32'(bm.FILL), 32'd4);
    send_byte(8'h66, 1'b1, 1'b0);
    chk("pp_fill", 32'(bm.FILL), 32'd4);
    chk("pp_ovf",  32'(bm.OVF),  32'h0);
    chk("pp_q",    32'(bm.Q),    32'hA2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain5_q%0d", i), 32'(bm.Q), 32'(drain5[i]));
      bm.RDY = 1'b1;
      step();
    end
    bm.RDY = 1'b0;
    chk("drain5_empty", 32'(bm.DV), 32'h0);

    // Asynchronous reset mid-byte with two bytes queued.
    send_byte(8'h12, 1'b0, 1'b0);
    send_byte(8'h34, 1'b0, 1'b0);
    bm.D  = 2'd1;
    bm.CE = 1'b1;
    step();
    step();
    bm.CE = 1'b0;
    chk("pre_rst_fill", 32'(bm.FILL), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_q",    32'(bm.Q),    32'h00);
    chk("async_rst_dv",   32'(bm.DV),   32'h0);
    chk("async_rst_fill", 32'(bm.FILL), 32'h0);
    step();
    rst = 1'b1;
    send_byte(8'h55, 1'b0, 1'b0);
    chk("post_rst_qm",   32'(bm.Q),    32'h55);
    chk("post_rst_ql",   32'(bl.Q),    32'h55);
    chk("post_rst_dv",   32'(bm.DV),   32'h1);
    chk("post_rst_fill", 32'(bm.FILL), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dibit_packer.md
Name: dibit_packer

Overview:
- Consumer stage directly downstream of the 2-input 2-bit latched multiplexer.
- Takes its registered 2-bit symbol output (one dibit per clock-enable strobe) and packs four dibits into one byte.
- Completed bytes go into a small synchronous FIFO; an output valid/ready handshake feeds the byte-wide framer or the host interface.
- Supports a flush of partially filled bytes and a sticky overflow flag.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of two, 2..16.
- MSB_FIRST, 1. 1: first dibit lands in bits [7:6]. 0: first dibit lands in bits [1:0].

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST  in  1  asynchronous active-low reset. Asserted (0): all state clears immediately. Released: synchronous to CLK.
- D    in  2  dibit from the upstream mux Q output.
- CE   in  1  dibit strobe; D is sampled on the CLK edge when CE=1.
- FLUSH  in  1  zero-pad and push the current partial byte.
- Q    out  8  byte at the FIFO head.
- DV   out  1  Q valid (FIFO not empty).
- RDY  in  1  downstream accepts Q when DV=1 and RDY=1 in the same cycle.
- FILL  out  clog2(DEPTH)+1  FIFO occupancy.
- OVF  out  1  sticky: a completed byte was dropped because the FIFO was full.
- CLR  in  1  synchronous clear of OVF only.

Behaviour:
- Reset (RST=0):
  - Q=0x00, DV=0, FILL=0, OVF=0.
  - Dibit counter=0, shift register=0, FIFO pointers=0.
  - Takes effect immediately, mid-byte included; a partial byte is discarded.
- Packer:
  - 2-bit counter CNT (0..3) plus an 8-bit assembly register.
  - On CE=1, D is written into slot CNT:
    - MSB_FIRST=1: bits [7-2*CNT : 6-2*CNT].
    - MSB_FIRST=0: bits [2*CNT+1 : 2*CNT].
  - CNT increments and wraps 3 to 0.
- Byte completion:
  - Occurs when CE=1 and CNT=3.
  - The assembled byte, including the current D, is presented to the FIFO push in the same cycle.
  - The assembly register clears to 0 on the same edge.
- FLUSH:
  - FLUSH=1 with CNT>0, or FLUSH=1 with CE=1: push the assembly register, including the current D when CE=1. Unused slots are 0.
  - After the push, CNT=0 and the register clears.
  - FLUSH=1 with CNT=0 and CE=0: no-op, no push.
  - FLUSH=1 with CE=1 and CNT=3: identical to normal completion; exactly one push.
- FIFO:
  - Registered head: Q and DV update one clock after the push edge.
  - Latency: the D sample edge of the 4th dibit to DV=1 is 1 cycle when the FIFO was empty.
  - Pop occurs when DV&RDY; Q advances to the next entry on the same edge.
  - Push and pop in the same cycle: FILL is unchanged, and the push is accepted even when FILL=DEPTH.
  - Push with FILL=DEPTH and no pop: the byte is dropped, FIFO contents are unchanged, and OVF is set on that edge.
  - Pointers wrap modulo DEPTH. FILL is never less than 0 or greater than DEPTH.
  - Q holds its last value when DV=0. Q is never X after reset.
- OVF:
  - Cleared only by reset or by CLR=1.
  - CLR and a new overflow in the same cycle: the set wins, so OVF=1.
- CE=0 and FLUSH=0: packer state holds; the FIFO still drains.

Decomposition:
- Shared package holds the constants:
  - DIBIT_W=2
  - BYTE_W=8
  - DIBITS_PER_BYTE=4
  - a clog2 function for FILL width
- One sub-module: byte_fifo_sync.
  - Ports: CLK, RST, push/data in, pop, Q/DV out, FILL, full.
  - Generic in width and depth; reusable by later framer stages.
- The packer, flush and OVF logic stay in dibit_packer.

Test Plan:
- Reset, then CE with D=0,3,1,2, MSB_FIRST=1, RDY=1 -> one cycle after the 4th dibit DV=1 and Q=0x36. The pop makes DV=0 on the next edge.
- Same dibits with MSB_FIRST=0 -> Q=0x9C.
- Dibits 3,1 then FLUSH=1 with CE=0, MSB_FIRST=1 -> Q=0xD0, CNT back to 0. FLUSH again with no CE -> no second byte.
- RDY=0, DEPTH=4, push 5 full bytes 0x11,0x22,0x33,0x44,0x55 -> FILL=4 and OVF=1 after the 5th. Then RDY=1 -> drains 0x11,0x22,0x33,0x44; 0x55 is absent and OVF stays 1 until CLR.
- FILL=4 and RDY=1, completing a byte 0x66 in the same cycle as a pop -> FILL stays 4, no OVF, 0x66 emerges last.
- RST low after 2 dibits while FILL=2 -> Q=0, DV=0, FILL=0 asynchronously. After release, the next 4 dibits 1,1,1,1 -> Q=0x55.
